// File: rtl/ladybird_inst_fetch_pkg.sv
// Shared types and constants for the ladybird instruction-fetch slice.
// LADYBIRD_FETCH_ALIGN_CHECK_EN adds the HALT state used by the misaligned-redirect trap.
package ladybird_config;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;
`else
  typedef enum logic {
    ST_RUN = 1'b0
  } fetch_state_e;
`endif

endpackage

// File: rtl/ladybird_fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries with a registered head output.
// Push and pop on a full queue in the same cycle are accepted; flush wins over both.
module ladybird_fetch_queue
  import ladybird_config::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  head_q, head_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign head    = head_q;
  assign count   = count_q;

  // The head register is reloaded from the array, or straight from push_data
  // when the pushed entry becomes the new head (array write not yet visible).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CW'(push_en) - CW'(pop_en);
      if (push_en && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_data;
      end else if (pop_en) begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ladybird_inst_fetch.sv
// Instruction-fetch initiator: sequential word reads, in-order response buffering, redirect flush.
// Define LADYBIRD_FETCH_ALIGN_CHECK_EN to trap misaligned redirects (inst_misaligned, HALT).
module ladybird_inst_fetch
  import ladybird_config::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic                  bus_req,
  output logic [XLEN-1:0]       bus_addr,
  output logic [INST_BYTES-1:0] bus_wstrb,
  output logic [XLEN-1:0]       bus_wdata,
  input  logic                  bus_gnt,
  input  logic [XLEN-1:0]       bus_rdata,
  input  logic                  bus_rdgnt,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [XLEN-1:0]       inst,
  output logic [XLEN-1:0]       inst_pc
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
  ,output logic                 inst_misaligned
`endif
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   occ;
  logic [XLEN-1:0] target_pc;
  logic            accept, dropping, push, pop, q_full, q_empty;
  fetch_entry_t    head;

`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
  logic            mis_q, mis_d;
  logic            target_mis;
  assign target_pc       = redirect_pc;
  assign target_mis      = |redirect_pc[1:0];
  assign inst_misaligned = mis_q;
`else
  assign target_pc = redirect_pc & ~XLEN'(INST_BYTES - 1);
`endif

  assign bus_wstrb = '0;
  assign bus_wdata = '0;
  assign bus_addr  = fetch_pc_q;
  assign bus_req   = nrst & (state_q == ST_RUN) & ~redirect_valid & ~q_full &
                     ((outst_q + occ) < CW'(QUEUE_DEPTH));
  assign accept    = bus_req & bus_gnt;
  assign dropping  = (drop_q != '0);
  assign push      = bus_rdgnt & ~dropping & ~redirect_valid;
  assign pop       = inst_valid & inst_ready & ~redirect_valid;

  assign inst_valid = ~q_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  ladybird_fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .nrst     (nrst),
    .push     (push),
    .push_data({resp_pc_q, bus_rdata}),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (occ)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(accept) - CW'(bus_rdgnt);
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
    mis_d      = mis_q;
`endif
    if (accept) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
    if (bus_rdgnt) begin
      if (dropping) drop_d    = drop_q - 1'b1;
      else          resp_pc_d = resp_pc_q + XLEN'(INST_BYTES);
    end
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      // Every read still in flight after this cycle is stale, including ones
      // already marked by an earlier redirect, so the count is reloaded.
      drop_d     = outst_q - CW'(bus_rdgnt);
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
      mis_d      = target_mis;
      state_d    = target_mis ? ST_HALT : ST_RUN;
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
      mis_q      <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_ladybird_inst_fetch.sv
// Bench for ladybird_inst_fetch: RAM with 1- or 2-cycle latency, epoch-tagged reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ladybird_inst_fetch;
  import ladybird_config::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        nrst;
  logic        bus_req, bus_gnt, bus_rdgnt;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        redirect_valid, inst_valid, inst_ready;
  logic [31:0] redirect_pc, inst, inst_pc;
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
  logic        inst_misaligned;
`endif

  always #5 clk = ~clk;

  ladybird_inst_fetch #(
    .RESET_PC   (RST_PC),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .bus_req       (bus_req),
    .bus_addr      (bus_addr),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_gnt       (bus_gnt),
    .bus_rdata     (bus_rdata),
    .bus_rdgnt     (bus_rdgnt),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
    ,.inst_misaligned(inst_misaligned)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    case (a)
      32'h0:   ram_word = 32'h0050_0093;  // addi x1, x0, 5
      32'h4:   ram_word = 32'h1234_5137;  // lui  x2, 0x12345
      32'h8:   ram_word = 32'h0011_0023;  // sb   x1, 0(x2)
      32'hC:   ram_word = 32'h0000_0013;  // nop
      default: ram_word = a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  // Instruction RAM: 1 or 2 cycles from accepted request to rdgnt pulse.
  int          lat    = 1;
  logic        gnt_en = 1'b1;
  logic        p1_v, p2_v;
  logic [31:0] p1_a, p2_a;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_a <= '0; p2_a <= '0;
    end else begin
      p1_v <= bus_req & bus_gnt;
      p1_a <= bus_addr;
      p2_v <= p1_v;
      p2_a <= p1_a;
    end
  end

  assign bus_gnt   = gnt_en;
  assign bus_rdgnt = (lat == 1) ? p1_v : p2_v;
  assign bus_rdata = (lat == 1) ? ram_word(p1_a) : ram_word(p2_a);

  // Reference model: reads are tagged with the redirect epoch at issue; a
  // returning read is kept only if no redirect happened since it was issued.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] ep;
  } flight_t;

  flight_t      infl[$];
  fetch_entry_t rq[$];
  fetch_entry_t popped[$];
  logic [31:0]  epoch   = '0;
  logic [31:0]  m_fetch = RST_PC;
  bit           m_halt  = 1'b0;
  bit           m_mis   = 1'b0;
  int           n_acc   = 0;

  initial forever begin
    bit          exp_req;
    flight_t     f;
    logic [31:0] tgt;
    @(negedge clk);
    check("wstrb", 32'(bus_wstrb), 32'd0);
    check("wdata", bus_wdata, 32'd0);
    if (!nrst) begin
      infl.delete(); rq.delete();
      m_fetch = RST_PC; m_halt = 1'b0; m_mis = 1'b0;
      check("rst_req", 32'(bus_req), 32'd0);
      check("rst_addr", bus_addr, RST_PC);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_pc", inst_pc, 32'd0);
    end else begin
      exp_req = !redirect_valid && !m_halt && (infl.size() + rq.size() < DEPTH);
      check("req", 32'(bus_req), 32'(exp_req));
      if (exp_req) check("addr", bus_addr, m_fetch);
      check("inst_valid", 32'(inst_valid), 32'(rq.size() != 0));
      if (rq.size() != 0) begin
        check("inst_pc", inst_pc, rq[0].pc);
        check("inst", inst, rq[0].inst);
      end
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
      check("misaligned", 32'(inst_misaligned), 32'(m_mis));
`endif
      if ((rq.size() != 0) && inst_ready && !redirect_valid) popped.push_back(rq.pop_front());
      if (bus_rdgnt) begin
        check("rdgnt_expected", 32'(infl.size() != 0), 32'd1);
        if (infl.size() != 0) begin
          f = infl.pop_front();
          if (!redirect_valid && f.ep == epoch) rq.push_back({f.a, ram_word(f.a)});
        end
      end
      if (exp_req && bus_gnt) begin
        infl.push_back({m_fetch, epoch});
        m_fetch += 32'd4;
        n_acc++;
      end
      if (redirect_valid) begin
        epoch++;
        rq.delete();
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
        tgt    = redirect_pc;
        m_mis  = (redirect_pc[1:0] != 2'b00);
        m_halt = m_mis;
`else
        tgt    = {redirect_pc[31:2], 2'b00};
`endif
        m_fetch = tgt;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    popped.delete();
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pops(input string name, input int n);
    for (int i = 0; i < 100 && popped.size() < n; i++) step(1);
    check(name, 32'(popped.size() >= n), 32'd1);
  endtask

  task automatic do_reset(input int latency);
    nrst = 1'b0;
    step(2);
    lat = latency;
    popped.delete();
    nrst = 1'b1;
  endtask

  function automatic logic [31:0] pc_at(input int k);
    pc_at = (popped.size() > k) ? popped[k].pc : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] inst_at(input int k);
    inst_at = (popped.size() > k) ? popped[k].inst : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int base;
    int hit;
    nrst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    step(1);
    do_reset(1);

    // 1: sequential stream from reset, with a short grant stall first
    gnt_en = 1'b0;
    step(2);
    check("t1_addr_held", bus_addr, 32'h0);
    gnt_en = 1'b1;
    wait_pops("t1_pops", 6);
    check("t1_pc0", pc_at(0), 32'h0);  check("t1_in0", inst_at(0), 32'h0050_0093);
    check("t1_pc1", pc_at(1), 32'h4);  check("t1_in1", inst_at(1), 32'h1234_5137);
    check("t1_pc2", pc_at(2), 32'h8);  check("t1_in2", inst_at(2), 32'h0011_0023);
    check("t1_pc3", pc_at(3), 32'hC);  check("t1_in3", inst_at(3), 32'h0000_0013);

    // 2: decode stalled -> exactly QUEUE_DEPTH reads, then one pop frees one slot
    inst_ready = 1'b0;
    redirect(32'h40);
    base = n_acc;
    step(20);
    check("t2_acc4", 32'(n_acc - base), 32'd4);
    check("t2_req_low", 32'(bus_req), 32'd0);
    inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0;
    step(10);
    check("t2_acc5", 32'(n_acc - base), 32'd5);
    check("t2_popped", 32'(popped.size()), 32'd1);
    check("t2_pc", pc_at(0), 32'h40);
    inst_ready = 1'b1;

    // 3: 2-cycle RAM, redirect with two reads outstanding, then back-to-back redirects
    do_reset(2);
    step(10);
    check("t3_inflight", 32'(infl.size()), 32'd2);
    redirect(32'h10);
    wait_pops("t3_pops", 2);
    check("t3_pc0", pc_at(0), 32'h10); check("t3_in0", inst_at(0), 32'h5A5A_5A4A);
    check("t3_pc1", pc_at(1), 32'h14); check("t3_in1", inst_at(1), 32'h5A5A_5A4E);
    redirect_valid = 1'b1; redirect_pc = 32'h100; step(1);
    redirect_pc = 32'h200; popped.delete(); step(1);
    redirect_valid = 1'b0;
    wait_pops("t3b_pops", 2);
    check("t3b_pc0", pc_at(0), 32'h200);
    check("t3b_pc1", pc_at(1), 32'h204);

    // 4: redirect coinciding with rdgnt and a pop
    do_reset(1);
    step(6);
    hit = 0;
    for (int i = 0; i < 20 && hit == 0; i++) begin
      if (bus_rdgnt && inst_valid) hit = 1;
      else step(1);
    end
    check("t4_found", 32'(hit), 32'd1);
    redirect(32'h80);
    check("t4_empty", 32'(inst_valid), 32'd0);
    wait_pops("t4_pops", 1);
    check("t4_pc0", pc_at(0), 32'h80);

    // 5: fetch address wraps at the top of the address space
    redirect(32'hFFFF_FFF8);
    wait_pops("t5_pops", 4);
    check("t5_pc0", pc_at(0), 32'hFFFF_FFF8); check("t5_in0", inst_at(0), 32'hA5A5_A5A2);
    check("t5_pc1", pc_at(1), 32'hFFFF_FFFC); check("t5_in1", inst_at(1), 32'hA5A5_A5A6);
    check("t5_pc2", pc_at(2), 32'h0);         check("t5_in2", inst_at(2), 32'h0050_0093);
    check("t5_pc3", pc_at(3), 32'h4);         check("t5_in3", inst_at(3), 32'h1234_5137);

    // 6: misaligned redirect
    redirect(32'h6);
    step(6);
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
    check("t6_mis", 32'(inst_misaligned), 32'd1);
    check("t6_req", 32'(bus_req), 32'd0);
    check("t6_valid", 32'(inst_valid), 32'd0);
    check("t6_none", 32'(popped.size()), 32'd0);
`else
    wait_pops("t6_pops", 1);
    check("t6_pc0", pc_at(0), 32'h4);
    check("t6_in0", inst_at(0), 32'h1234_5137);
`endif
    redirect(32'h8);
    wait_pops("t6b_pops", 1);
    check("t6b_pc0", pc_at(0), 32'h8);
    check("t6b_in0", inst_at(0), 32'h0011_0023);
`ifdef LADYBIRD_FETCH_ALIGN_CHECK_EN
    check("t6b_mis", 32'(inst_misaligned), 32'd0);
`endif

    // 7: asynchronous reset in the middle of streaming
    step(3);
    nrst = 1'b0;
    #1;
    check("t7_req", 32'(bus_req), 32'd0);
    check("t7_valid", 32'(inst_valid), 32'd0);
    check("t7_addr", bus_addr, RST_PC);
    step(2);
    popped.delete();
    nrst = 1'b1;
    wait_pops("t7_pops", 2);
    check("t7_pc0", pc_at(0), RST_PC);
    check("t7_pc1", pc_at(1), 32'h4);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
